ex_stage: RTL and testbench



---
 rtl/ex_stage_if.sv | 56 +++++
 rtl/ex_stage.sv | 319 +++++++++++++++++++++++++++++++
 tb/tb_ex_stage.sv | 394 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : ex_stage_if
//  Description : ID/EX operands and controls, forwarding sources and EX
//                results of the MIPS execute stage, bundled as one interface.
//                The master side is the surrounding pipeline, the slave side
//                is ex_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ex_stage_if;
    logic        flush;
    logic [31:0] ex_inst;
    logic [8:0]  ex_pc_4;
    logic [31:0] ex_data1;
    logic [31:0] ex_data2;
    logic [31:0] ex_extend;
    logic        ex_alusrc;
    logic        ex_regread1;
    logic        ex_regread2;
    logic        ex_branch;
    logic        ex_branchne;
    logic        ex_jump;
    logic        ex_jumpr;
    logic        ex_link;
    logic [4:0]  ex_wraddr;
    logic        mem_regwrite;
    logic        wb_regwrite;
    logic [4:0]  mem_wraddr;
    logic [4:0]  wb_wraddr;
    logic [31:0] mem_result;
    logic [31:0] wb_result;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic        redirect;
    logic [8:0]  redirect_pc;
    logic        md_stall;

    modport master (
        output flush, ex_inst, ex_pc_4, ex_data1, ex_data2, ex_extend,
               ex_alusrc, ex_regread1, ex_regread2, ex_branch, ex_branchne,
               ex_jump, ex_jumpr, ex_link, ex_wraddr,
               mem_regwrite, wb_regwrite, mem_wraddr, wb_wraddr,
               mem_result, wb_result,
        input  alu_result, store_data, redirect, redirect_pc, md_stall
    );

    modport slave (
        input  flush, ex_inst, ex_pc_4, ex_data1, ex_data2, ex_extend,
               ex_alusrc, ex_regread1, ex_regread2, ex_branch, ex_branchne,
               ex_jump, ex_jumpr, ex_link, ex_wraddr,
               mem_regwrite, wb_regwrite, mem_wraddr, wb_wraddr,
               mem_result, wb_result,
        output alu_result, store_data, redirect, redirect_pc, md_stall
    );
endinterface
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_stage
//  Description : Execute stage of the 5-stage MIPS pipeline: operand
//                forwarding, integer ALU, branch/jump resolution and an
//                iterative multiply/divide unit owning the HI/LO registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_stage #(
    parameter int MD_ITER = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    ex_stage_if.slave bus
);

    localparam int CNT_W = (MD_ITER > 1) ? $clog2(MD_ITER) : 1;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_busy = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_addiu = 6'h09;
    localparam logic [5:0] c_op_slti  = 6'h0A;
    localparam logic [5:0] c_op_sltiu = 6'h0B;
    localparam logic [5:0] c_op_andi  = 6'h0C;
    localparam logic [5:0] c_op_ori   = 6'h0D;
    localparam logic [5:0] c_op_xori  = 6'h0E;
    localparam logic [5:0] c_op_lui   = 6'h0F;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;

    localparam logic [5:0] c_fn_sll  = 6'h00;
    localparam logic [5:0] c_fn_srl  = 6'h02;
    localparam logic [5:0] c_fn_sra  = 6'h03;
    localparam logic [5:0] c_fn_sllv = 6'h04;
    localparam logic [5:0] c_fn_srlv = 6'h06;
    localparam logic [5:0] c_fn_srav = 6'h07;
    localparam logic [5:0] c_fn_mfhi = 6'h10;
    localparam logic [5:0] c_fn_mthi = 6'h11;
    localparam logic [5:0] c_fn_mflo = 6'h12;
    localparam logic [5:0] c_fn_mtlo = 6'h13;
    localparam logic [5:0] c_fn_add  = 6'h20;
    localparam logic [5:0] c_fn_addu = 6'h21;
    localparam logic [5:0] c_fn_sub  = 6'h22;
    localparam logic [5:0] c_fn_subu = 6'h23;
    localparam logic [5:0] c_fn_and  = 6'h24;
    localparam logic [5:0] c_fn_or   = 6'h25;
    localparam logic [5:0] c_fn_xor  = 6'h26;
    localparam logic [5:0] c_fn_nor  = 6'h27;
    localparam logic [5:0] c_fn_slt  = 6'h2A;
    localparam logic [5:0] c_fn_sltu = 6'h2B;

    // Instruction fields
    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    logic [4:0]  w_shamt;
    logic [4:0]  w_rs_addr;
    logic [4:0]  w_rt_addr;

    assign w_opcode  = bus.ex_inst[31:26];
    assign w_funct   = bus.ex_inst[5:0];
    assign w_shamt   = bus.ex_inst[10:6];
    assign w_rs_addr = bus.ex_inst[25:21];
    assign w_rt_addr = bus.ex_inst[20:16];

    // Forwarded operands
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;
    logic [31:0] w_op_b;

    // Architectural and multiply/divide state
    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [CNT_W-1:0]  r_count;
    logic [31:0]       r_hi;
    logic [31:0]       r_lo;
    logic [31:0]       r_acc_hi;
    logic [31:0]       r_acc_lo;
    logic [31:0]       r_opnd;
    logic [31:0]       r_rs_raw;
    logic              r_neg_res;
    logic              r_neg_rem;
    logic              r_is_div;
    logic              r_div_zero;

    // Rs operand: MEM result beats WB result, r0 is never forwarded
    always_comb begin
        w_rs_val = bus.ex_data1;
        if (bus.mem_regwrite && (bus.mem_wraddr != 5'd0) && (bus.mem_wraddr == w_rs_addr))
            w_rs_val = bus.mem_result;
        else if (bus.wb_regwrite && (bus.wb_wraddr != 5'd0) && (bus.wb_wraddr == w_rs_addr))
            w_rs_val = bus.wb_result;
    end

    // Rt operand: same priority as rs
    always_comb begin
        w_rt_val = bus.ex_data2;
        if (bus.mem_regwrite && (bus.mem_wraddr != 5'd0) && (bus.mem_wraddr == w_rt_addr))
            w_rt_val = bus.mem_result;
        else if (bus.wb_regwrite && (bus.wb_wraddr != 5'd0) && (bus.wb_wraddr == w_rt_addr))
            w_rt_val = bus.wb_result;
    end

    assign w_op_b         = bus.ex_alusrc ? bus.ex_extend : w_rt_val;
    assign bus.store_data = w_rt_val;

    // Integer ALU plus HI/LO reads; everything wraps, nothing traps
    logic [31:0] w_alu;
    always_comb begin
        w_alu = 32'h0;
        case (w_opcode)
            c_op_rtype: begin
                case (w_funct)
                    c_fn_sll:  w_alu = w_rt_val << w_shamt;
                    c_fn_srl:  w_alu = w_rt_val >> w_shamt;
                    c_fn_sra:  w_alu = $signed(w_rt_val) >>> w_shamt;
                    c_fn_sllv: w_alu = w_rt_val << w_rs_val[4:0];
                    c_fn_srlv: w_alu = w_rt_val >> w_rs_val[4:0];
                    c_fn_srav: w_alu = $signed(w_rt_val) >>> w_rs_val[4:0];
                    c_fn_mfhi: w_alu = r_hi;
                    c_fn_mflo: w_alu = r_lo;
                    c_fn_add, c_fn_addu: w_alu = w_rs_val + w_op_b;
                    c_fn_sub, c_fn_subu: w_alu = w_rs_val - w_op_b;
                    c_fn_and:  w_alu = w_rs_val & w_op_b;
                    c_fn_or:   w_alu = w_rs_val | w_op_b;
                    c_fn_xor:  w_alu = w_rs_val ^ w_op_b;
                    c_fn_nor:  w_alu = ~(w_rs_val | w_op_b);
                    c_fn_slt:  w_alu = {31'h0, $signed(w_rs_val) < $signed(w_op_b)};
                    c_fn_sltu: w_alu = {31'h0, w_rs_val < w_op_b};
                    default:   w_alu = 32'h0;
                endcase
            end
            c_op_addi, c_op_addiu, c_op_lw, c_op_sw: w_alu = w_rs_val + w_op_b;
            c_op_slti:  w_alu = {31'h0, $signed(w_rs_val) < $signed(w_op_b)};
            c_op_sltiu: w_alu = {31'h0, w_rs_val < w_op_b};
            c_op_andi:  w_alu = w_rs_val & w_op_b;
            c_op_ori:   w_alu = w_rs_val | w_op_b;
            c_op_xori:  w_alu = w_rs_val ^ w_op_b;
            c_op_lui:   w_alu = {bus.ex_inst[15:0], 16'h0};
            default:    w_alu = 32'h0;
        endcase
    end

    // Linking instructions return the return address (no delay slot)
    assign bus.alu_result = bus.ex_link ? {23'h0, bus.ex_pc_4} : w_alu;

    // Branch/jump resolution; jumps beat branches, flush cancels everything
    logic       w_rs_eq_rt;
    logic       w_br_taken;
    logic [8:0] w_br_target;
    logic [8:0] w_j_target;

    assign w_rs_eq_rt  = (w_rs_val == w_rt_val);
    assign w_br_taken  = (bus.ex_branch & w_rs_eq_rt) | (bus.ex_branchne & ~w_rs_eq_rt);
    assign w_br_target = bus.ex_pc_4 + {bus.ex_extend[6:0], 2'b00};
    assign w_j_target  = {bus.ex_inst[6:0], 2'b00};

    // Select the redirect target and qualify the redirect with flush
    always_comb begin
        bus.redirect    = 1'b0;
        bus.redirect_pc = bus.ex_pc_4;
        if (bus.ex_jumpr) begin
            bus.redirect_pc = w_rs_val[8:0];
            bus.redirect    = ~bus.flush;
        end else if (bus.ex_jump) begin
            bus.redirect_pc = w_j_target;
            bus.redirect    = ~bus.flush;
        end else if (w_br_taken) begin
            bus.redirect_pc = w_br_target;
            bus.redirect    = ~bus.flush;
        end
    end

    // Multiply/divide decode: funct 0x18..0x1B, bit1 = divide, bit0 = unsigned
    logic        w_md_op;
    logic        w_md_signed;
    logic        w_md_start;
    logic        w_md_last;
    logic [31:0] w_rs_mag;
    logic [31:0] w_rt_mag;

    assign w_md_op     = (w_opcode == c_op_rtype) && (w_funct[5:2] == 4'b0110);
    assign w_md_signed = ~w_funct[0];
    assign w_md_start  = (r_state == c_st_idle) && w_md_op && !bus.flush;
    assign w_md_last   = (r_count == CNT_W'(MD_ITER - 1));
    assign w_rs_mag    = (w_md_signed && w_rs_val[31]) ? (32'h0 - w_rs_val) : w_rs_val;
    assign w_rt_mag    = (w_md_signed && w_rt_val[31]) ? (32'h0 - w_rt_val) : w_rt_val;

    // One iteration: shift-add for multiply, restoring subtract for divide
    logic [32:0] w_mul_sum;
    logic [32:0] w_div_shift;
    logic [33:0] w_div_diff;
    logic [31:0] w_step_hi;
    logic [31:0] w_step_lo;

    assign w_mul_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : 33'h0);
    assign w_div_shift = {r_acc_hi, r_acc_lo[31]};
    assign w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_opnd};

    // Next accumulator values for the current iteration
    always_comb begin
        w_step_hi = w_mul_sum[32:1];
        w_step_lo = {w_mul_sum[0], r_acc_lo[31:1]};
        if (r_is_div) begin
            if (!w_div_diff[33]) begin
                w_step_hi = w_div_diff[31:0];
                w_step_lo = {r_acc_lo[30:0], 1'b1};
            end else begin
                w_step_hi = w_div_shift[31:0];
                w_step_lo = {r_acc_lo[30:0], 1'b0};
            end
        end
    end

    // Sign-corrected final results
    logic [63:0] w_prod;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    assign w_prod     = {w_step_hi, w_step_lo};
    assign w_prod_fix = r_neg_res ? (64'h0 - w_prod) : w_prod;
    assign w_quo_fix  = r_neg_res ? (32'h0 - w_step_lo) : w_step_lo;
    assign w_rem_fix  = r_neg_rem ? (32'h0 - w_step_hi) : w_step_hi;

    // Multiply/divide state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= c_st_idle;
        else
            r_state <= w_state_next;
    end

    // Multiply/divide next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: if (w_md_start) w_state_next = c_st_busy;
            c_st_busy: begin
                if (bus.flush)
                    w_state_next = c_st_idle;
                else if (w_md_last)
                    w_state_next = c_st_done;
            end
            c_st_done: w_state_next = c_st_idle;
            default:   w_state_next = c_st_idle;
        endcase
    end

    // Stall the front end while an operation is starting or iterating
    always_comb begin
        bus.md_stall = 1'b0;
        case (r_state)
            c_st_idle: bus.md_stall = w_md_op & ~bus.flush;
            c_st_busy: bus.md_stall = 1'b1;
            default:   bus.md_stall = 1'b0;
        endcase
    end

    // Operand capture on start, one iteration per BUSY cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_acc_hi   <= 32'h0;
            r_acc_lo   <= 32'h0;
            r_opnd     <= 32'h0;
            r_rs_raw   <= 32'h0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_is_div   <= 1'b0;
            r_div_zero <= 1'b0;
        end else if (w_md_start) begin
            r_count    <= '0;
            r_acc_hi   <= 32'h0;
            r_acc_lo   <= w_rs_mag;
            r_opnd     <= w_rt_mag;
            r_rs_raw   <= w_rs_val;
            r_neg_res  <= w_md_signed & (w_rs_val[31] ^ w_rt_val[31]);
            r_neg_rem  <= w_md_signed & w_rs_val[31];
            r_is_div   <= w_funct[1];
            r_div_zero <= (w_rt_val == 32'h0);
        end else if (r_state == c_st_busy) begin
            r_count  <= r_count + CNT_W'(1);
            r_acc_hi <= w_step_hi;
            r_acc_lo <= w_step_lo;
        end
    end

    // HI/LO: completed multiply/divide, or MTHI/MTLO from the EX instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= 32'h0;
            r_lo <= 32'h0;
        end else if ((r_state == c_st_busy) && w_md_last && !bus.flush) begin
            if (!r_is_div) begin
                r_hi <= w_prod_fix[63:32];
                r_lo <= w_prod_fix[31:0];
            end else if (r_div_zero) begin
                r_hi <= r_rs_raw;
                r_lo <= 32'hFFFF_FFFF;
            end else begin
                r_hi <= w_rem_fix;
                r_lo <= w_quo_fix;
            end
        end else if (!bus.flush && (w_opcode == c_op_rtype)) begin
            if (w_funct == c_fn_mthi) r_hi <= w_rs_val;
            if (w_funct == c_fn_mtlo) r_lo <= w_rs_val;
        end
    end

    // Register-read flags and destination pass straight through ID/EX to EX/MEM
    logic w_unused_ok;
    assign w_unused_ok = ^{bus.ex_regread1, bus.ex_regread2, bus.ex_wraddr, w_div_diff[32]};

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_stage
//  Description : Self-checking bench for ex_stage. Expected values are queued
//                when stimulus is applied and popped when outputs are sampled.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ex_stage;

    localparam logic [31:0] c_nop = 32'h0000_0020;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ex_stage_if bus ();

    ex_stage #(.MD_ITER(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    int       n_checks = 0;
    int       n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.exp = exp;
        sb_q.push_back(it);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        sb_item_t it;
        if (sb_q.size() == 0) begin
            it.tag = "sb_underflow";
            it.exp = ~obs;
        end else begin
            it = sb_q.pop_front();
        end
        check_val(it.tag, obs, it.exp);
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] sh);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Reference {HI,LO} for the four multiply/divide instructions
    function automatic logic [63:0] md_model(input logic [5:0] fn, input logic [31:0] a,
                                             input logic [31:0] b);
        logic signed [63:0] sa64;
        logic signed [63:0] sb64;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic        [31:0] q;
        logic        [31:0] r;
        sa64 = $signed(a);
        sb64 = $signed(b);
        sa   = a;
        sb   = b;
        case (fn)
            6'h18:   return sa64 * sb64;
            6'h19:   return {32'h0, a} * {32'h0, b};
            6'h1A: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic clear_ctrl();
        bus.flush        = 1'b0;
        bus.ex_inst      = c_nop;
        bus.ex_pc_4      = 9'h0;
        bus.ex_data1     = 32'h0;
        bus.ex_data2     = 32'h0;
        bus.ex_extend    = 32'h0;
        bus.ex_alusrc    = 1'b0;
        bus.ex_regread1  = 1'b0;
        bus.ex_regread2  = 1'b0;
        bus.ex_branch    = 1'b0;
        bus.ex_branchne  = 1'b0;
        bus.ex_jump      = 1'b0;
        bus.ex_jumpr     = 1'b0;
        bus.ex_link      = 1'b0;
        bus.ex_wraddr    = 5'd0;
        bus.mem_regwrite = 1'b0;
        bus.wb_regwrite  = 1'b0;
        bus.mem_wraddr   = 5'd0;
        bus.wb_wraddr    = 5'd0;
        bus.mem_result   = 32'h0;
        bus.wb_result    = 32'h0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Apply an ALU-type instruction and check alu_result combinationally
    task automatic alu_case(input string tag, input logic [31:0] inst, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] ext, input logic alusrc,
                            input logic [31:0] exp);
        next_cycle();
        clear_ctrl();
        bus.ex_inst   = inst;
        bus.ex_data1  = a;
        bus.ex_data2  = b;
        bus.ex_extend = ext;
        bus.ex_alusrc = alusrc;
        sb_push(tag, exp);
        @(negedge clk);
        sb_pop(bus.alu_result);
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        next_cycle();
        clear_ctrl();
        bus.ex_inst = rtype(6'h10, 5'd0, 5'd0, 5'd3, 5'd0);
        sb_push({tag, "_hi"}, exp_hi);
        @(negedge clk);
        sb_pop(bus.alu_result);
        next_cycle();
        bus.ex_inst = rtype(6'h12, 5'd0, 5'd0, 5'd3, 5'd0);
        sb_push({tag, "_lo"}, exp_lo);
        @(negedge clk);
        sb_pop(bus.alu_result);
    endtask

    // Run a multiply/divide to completion, count stall cycles, then MFHI/MFLO
    task automatic md_run(input string tag, input logic [5:0] fn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        next_cycle();
        clear_ctrl();
        bus.ex_inst  = rtype(fn, 5'd1, 5'd2, 5'd0, 5'd0);
        bus.ex_data1 = a;
        bus.ex_data2 = b;
        sb_push({tag, "_stall_cycles"}, 32'd33);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.md_stall) break;
            n++;
            next_cycle();
        end
        sb_pop(32'(n));
        read_hilo(tag, exp_hi, exp_lo);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] exp64;
        logic [5:0]  fn;
        logic [31:0] ra;
        logic [31:0] rb;

        clear_ctrl();
        rst_n         = 1'b0;
        bus.ex_data1  = 32'd3;
        bus.ex_data2  = 32'd4;
        bus.ex_pc_4   = 9'h0AC;

        // Reset state with the reset NOP in EX
        sb_push("rst_md_stall", 32'd0);
        sb_push("rst_nop_sum", 32'd7);
        sb_push("rst_redirect", 32'd0);
        sb_push("rst_redirect_pc", 32'h0AC);
        repeat (2) @(posedge clk);
        @(negedge clk);
        sb_pop({31'h0, bus.md_stall});
        sb_pop(bus.alu_result);
        sb_pop({31'h0, bus.redirect});
        sb_pop({23'h0, bus.redirect_pc});
        next_cycle();
        rst_n = 1'b1;
        read_hilo("rst_hilo", 32'h0, 32'h0);

        // Forwarding: MEM beats WB, WB alone, r0 never forwarded, store data
        next_cycle();
        clear_ctrl();
        bus.ex_inst      = rtype(6'h20, 5'd5, 5'd0, 5'd3, 5'd0);
        bus.ex_data1     = 32'h1;
        bus.mem_regwrite = 1'b1; bus.mem_wraddr = 5'd5; bus.mem_result = 32'h10;
        bus.wb_regwrite  = 1'b1; bus.wb_wraddr  = 5'd5; bus.wb_result  = 32'h20;
        sb_push("fwd_mem_wins", 32'h10);
        @(negedge clk);
        sb_pop(bus.alu_result);
        next_cycle();
        bus.mem_regwrite = 1'b0;
        sb_push("fwd_wb_only", 32'h20);
        @(negedge clk);
        sb_pop(bus.alu_result);
        next_cycle();
        clear_ctrl();
        bus.ex_inst      = rtype(6'h20, 5'd0, 5'd0, 5'd3, 5'd0);
        bus.ex_data1     = 32'h1;
        bus.mem_regwrite = 1'b1; bus.mem_wraddr = 5'd0; bus.mem_result = 32'hFF;
        sb_push("fwd_r0_blocked", 32'h1);
        @(negedge clk);
        sb_pop(bus.alu_result);
        next_cycle();
        clear_ctrl();
        bus.ex_inst     = itype(6'h2B, 5'd1, 5'd6, 16'h4);
        bus.ex_data2    = 32'h11;
        bus.wb_regwrite = 1'b1; bus.wb_wraddr = 5'd6; bus.wb_result = 32'h77;
        sb_push("fwd_store_data", 32'h77);
        @(negedge clk);
        sb_pop(bus.store_data);

        // ALU sweep
        alu_case("slt_signed",  rtype(6'h2A, 5'd1, 5'd2, 5'd3, 5'd0), 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 32'h1);
        alu_case("sltu",        rtype(6'h2B, 5'd1, 5'd2, 5'd3, 5'd0), 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 32'h0);
        alu_case("sra",         rtype(6'h03, 5'd0, 5'd2, 5'd3, 5'd4), 32'h0, 32'h8000_0000, 32'h0, 1'b0, 32'hF800_0000);
        alu_case("lui",         itype(6'h0F, 5'd0, 5'd3, 16'h1234), 32'h0, 32'h0, 32'h1234, 1'b1, 32'h1234_0000);
        alu_case("addu_wrap",   rtype(6'h21, 5'd1, 5'd2, 5'd3, 5'd0), 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 32'h0);
        alu_case("sllv",        rtype(6'h04, 5'd1, 5'd2, 5'd3, 5'd0), 32'h24, 32'h1, 32'h0, 1'b0, 32'h10);
        alu_case("sub",         rtype(6'h22, 5'd1, 5'd2, 5'd3, 5'd0), 32'h5, 32'h7, 32'h0, 1'b0, 32'hFFFF_FFFE);
        alu_case("nor",         rtype(6'h27, 5'd1, 5'd2, 5'd3, 5'd0), 32'hF0F0_0000, 32'h0000_0F0F, 32'h0, 1'b0, 32'h0F0F_F0F0);
        alu_case("slti",        itype(6'h0A, 5'd1, 5'd3, 16'hFFFF), 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF, 1'b1, 32'h1);
        alu_case("lw_addr",     itype(6'h23, 5'd1, 5'd3, 16'hFFFC), 32'h100, 32'h0, 32'hFFFF_FFFC, 1'b1, 32'hFC);

        // Branch and jump resolution
        next_cycle();
        clear_ctrl();
        bus.ex_inst   = itype(6'h04, 5'd1, 5'd2, 16'hFFFE);
        bus.ex_branch = 1'b1;
        bus.ex_data1  = 32'h7; bus.ex_data2 = 32'h7;
        bus.ex_pc_4   = 9'h100; bus.ex_extend = 32'hFFFF_FFFE;
        sb_push("beq_redirect", 32'd1);
        sb_push("beq_target", 32'h0F8);
        @(negedge clk);
        sb_pop({31'h0, bus.redirect});
        sb_pop({23'h0, bus.redirect_pc});
        next_cycle();
        bus.flush = 1'b1;
        sb_push("beq_flushed", 32'd0);
        @(negedge clk);
        sb_pop({31'h0, bus.redirect});
        next_cycle();
        bus.flush       = 1'b0;
        bus.ex_branch   = 1'b0;
        bus.ex_branchne = 1'b1;
        sb_push("bne_equal_not_taken", 32'd0);
        sb_push("bne_pc_falls_through", 32'h100);
        @(negedge clk);
        sb_pop({31'h0, bus.redirect});
        sb_pop({23'h0, bus.redirect_pc});
        next_cycle();
        clear_ctrl();
        bus.ex_inst  = rtype(6'h08, 5'd1, 5'd0, 5'd0, 5'd0);
        bus.ex_jumpr = 1'b1;
        bus.ex_data1 = 32'h1234;
        sb_push("jr_target", 32'h034);
        @(negedge clk);
        sb_pop({23'h0, bus.redirect_pc});
        next_cycle();
        clear_ctrl();
        bus.ex_inst = {6'h03, 26'h15};
        bus.ex_jump = 1'b1; bus.ex_link = 1'b1; bus.ex_pc_4 = 9'h044;
        sb_push("jal_link", 32'h044);
        sb_push("jal_target", 32'h054);
        @(negedge clk);
        sb_pop(bus.alu_result);
        sb_pop({23'h0, bus.redirect_pc});

        // Multiply/divide with fixed corner cases
        md_run("mult_neg3x7", 6'h18, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        md_run("div_neg7by2", 6'h1A, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        md_run("divu_by0",    6'h1B, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
        md_run("div_ovf",     6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

        // Multiply/divide with random operands against the reference model
        for (int i = 0; i < 4; i++) begin
            fn    = 6'h18 + 6'(i);
            ra    = $urandom;
            rb    = $urandom;
            exp64 = md_model(fn, ra, rb);
            md_run($sformatf("md_rand%0d", i), fn, ra, rb, exp64[63:32], exp64[31:0]);
        end

        // MTHI/MTLO, then abort a multiply with flush in BUSY cycle 10
        next_cycle();
        clear_ctrl();
        bus.ex_inst  = rtype(6'h11, 5'd1, 5'd0, 5'd0, 5'd0);
        bus.ex_data1 = 32'hAAAA;
        next_cycle();
        bus.ex_inst  = rtype(6'h13, 5'd1, 5'd0, 5'd0, 5'd0);
        bus.ex_data1 = 32'h5555;
        read_hilo("mthi_mtlo", 32'hAAAA, 32'h5555);
        next_cycle();
        clear_ctrl();
        bus.ex_inst  = rtype(6'h18, 5'd1, 5'd2, 5'd0, 5'd0);
        bus.ex_data1 = 32'd3;
        bus.ex_data2 = 32'd7;
        repeat (11) next_cycle();
        bus.flush = 1'b1;
        sb_push("abort_stall_busy", 32'd1);
        @(negedge clk);
        sb_pop({31'h0, bus.md_stall});
        next_cycle();
        bus.flush   = 1'b0;
        bus.ex_inst = c_nop;
        sb_push("abort_stall_drop", 32'd0);
        @(negedge clk);
        sb_pop({31'h0, bus.md_stall});
        read_hilo("abort_hilo", 32'hAAAA, 32'h5555);

        // Flush together with an md op in IDLE: no start, no stall
        next_cycle();
        clear_ctrl();
        bus.ex_inst  = rtype(6'h1A, 5'd1, 5'd2, 5'd0, 5'd0);
        bus.ex_data1 = 32'd9;
        bus.ex_data2 = 32'd3;
        bus.flush    = 1'b1;
        sb_push("flush_idle_stall", 32'd0);
        @(negedge clk);
        sb_pop({31'h0, bus.md_stall});
        next_cycle();
        clear_ctrl();
        sb_push("flush_idle_no_start", 32'd0);
        @(negedge clk);
        sb_pop({31'h0, bus.md_stall});
        read_hilo("flush_idle_hilo", 32'hAAAA, 32'h5555);

        // Asynchronous reset in the middle of BUSY
        next_cycle();
        clear_ctrl();
        bus.ex_inst  = rtype(6'h19, 5'd1, 5'd2, 5'd0, 5'd0);
        bus.ex_data1 = 32'd5;
        bus.ex_data2 = 32'd5;
        repeat (5) next_cycle();
        rst_n = 1'b0;
        #1;
        bus.ex_inst = rtype(6'h10, 5'd0, 5'd0, 5'd3, 5'd0);
        sb_push("rst_mid_hi", 32'h0);
        sb_push("rst_mid_stall", 32'd0);
        @(negedge clk);
        sb_pop(bus.alu_result);
        sb_pop({31'h0, bus.md_stall});
        next_cycle();
        bus.ex_inst = rtype(6'h12, 5'd0, 5'd0, 5'd3, 5'd0);
        sb_push("rst_mid_lo", 32'h0);
        @(negedge clk);
        sb_pop(bus.alu_result);
        next_cycle();
        rst_n       = 1'b1;
        bus.ex_inst = c_nop;
        sb_push("rst_mid_idle", 32'd0);
        @(negedge clk);
        sb_pop({31'h0, bus.md_stall});

        check_val("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
